// File: rtl/mips_cpu_main_control.sv
// Multicycle main control FSM for the MIPS CPU: sequences fetch/decode/exec/mem/wb,
// drives datapath strobes and ALUOp, and flags memory accesses that stall too long.
module mips_cpu_main_control #(
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       jr_target_zero,
    input  logic       waitrequest,
    output logic [3:0] ALUOp,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       reg_write,
    output logic [1:0] pc_source,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       active,
    output logic       mem_timeout
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;

    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t             state_q, state_d;
    logic               active_q, active_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            active_q      <= 1'b0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            stall_cnt_q   <= stall_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ALUOp         = 4'b0000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        pc_source     = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 1'b0;
        case (state_q)
            FETCH: begin
                // active_q is low only in the cycle between reset release and the first edge
                if (active_q) begin
                    mem_read  = 1'b1;
                    ALUOp     = 4'b0011;
                    alu_src_b = 2'b01;
                    if (!waitrequest) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
            end
            DECODE: begin
                ALUOp     = 4'b0011;
                alu_src_b = 2'b11;
                state_d   = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        ALUOp     = 4'b0010;
                        alu_src_a = 1'b1;
                        if (funct == FN_JR) begin
                            pc_source = 2'b11;
                            pc_write  = 1'b1;
                            state_d   = jr_target_zero ? HALT : FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end
                    OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: begin
                        case (opcode)
                            OP_ANDI:  ALUOp = 4'b0100;
                            OP_ORI:   ALUOp = 4'b0101;
                            OP_XORI:  ALUOp = 4'b0110;
                            OP_SLTIU: ALUOp = 4'b0111;
                            default:  ALUOp = 4'b0000;
                        endcase
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = MEM;
                    end
                    OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_REGIMM: begin
                        case (opcode)
                            OP_BEQ:  ALUOp = 4'b0001;
                            OP_BNE:  ALUOp = 4'b1000;
                            OP_BGTZ: ALUOp = 4'b1001;
                            OP_BLEZ: ALUOp = 4'b1010;
                            default: ALUOp = 4'b1011;
                        endcase
                        alu_src_a     = 1'b1;
                        pc_source     = 2'b01;
                        pc_write_cond = 1'b1;
                    end
                    OP_J, OP_JAL: begin
                        pc_source = 2'b10;
                        pc_write  = 1'b1;
                        if (opcode == OP_JAL) begin
                            reg_write = 1'b1;
                            reg_dst   = 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
            MEM: begin
                iord      = 1'b1;
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode != OP_LW);
                if (!waitrequest) state_d = (opcode == OP_LW) ? WB : FETCH;
            end
            WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
                if (opcode == OP_LW)         mem_to_reg = 1'b1;
                else if (opcode == OP_RTYPE) reg_dst    = 2'b01;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        active_d      = (state_d != HALT);
        stall_cnt_d   = stall_cnt_q;
        mem_timeout_d = mem_timeout_q;
        // Counter saturates at the limit; the FSM itself never gives up on a stalled access
        if ((mem_read || mem_write) && waitrequest) begin
            if (stall_cnt_q != TIMEOUT_V) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if ((WAIT_TIMEOUT != 0) && (stall_cnt_d == TIMEOUT_V)) mem_timeout_d = 1'b1;
        end else if (mem_read || mem_write) begin
            stall_cnt_d = '0;
        end
    end

    assign active      = active_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_mips_cpu_main_control.sv
// Randomized self-checking bench for mips_cpu_main_control: a per-instruction cycle
// sequence model produces expected output vectors that are compared each cycle.
module tb_mips_cpu_main_control;

    localparam int WT = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       jr_target_zero = 1'b0;
    logic       waitrequest = 1'b0;
    logic [3:0] ALUOp;
    logic       alu_src_a, iord, mem_read, mem_write, ir_write, pc_write;
    logic       pc_write_cond, reg_write, mem_to_reg, active, mem_timeout;
    logic [1:0] alu_src_b, pc_source, reg_dst;

    int checks = 0;
    int errors = 0;

    mips_cpu_main_control #(.WAIT_TIMEOUT(WT)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .jr_target_zero(jr_target_zero), .waitrequest(waitrequest),
        .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
        .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .active(active), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    logic [19:0] act_vec;
    assign act_vec = {ALUOp, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                      pc_write, pc_write_cond, reg_write, pc_source, reg_dst, mem_to_reg, active};

    typedef struct {
        logic [19:0] e;
        logic        wr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        jrz;
    } cyc_t;

    cyc_t q[$];

    function automatic logic [19:0] ev(int aop, int sa, int sb, int io, int mr, int mw,
                                       int irw, int pcw, int pcwc, int rw, int pcs,
                                       int rd, int m2r, int act);
        return {4'(aop), 1'(sa), 2'(sb), 1'(io), 1'(mr), 1'(mw), 1'(irw), 1'(pcw),
                1'(pcwc), 1'(rw), 2'(pcs), 2'(rd), 1'(m2r), 1'(act)};
    endfunction

    function automatic void push(logic [19:0] e, logic wr, logic [5:0] op, logic [5:0] fn,
                                 logic jrz);
        cyc_t c;
        c.e = e; c.wr = wr; c.op = op; c.fn = fn; c.jrz = jrz;
        q.push_back(c);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference model: expected per-cycle outputs for one whole instruction.
    function automatic void model_instr(logic [5:0] op, logic [5:0] fn, logic jrz,
                                        int fs, int ms);
        int          ialu, balu;
        bit          is_imm, is_br;
        logic [19:0] ex;
        is_imm = 1'b1; ialu = 0;
        case (op)
            6'd9: ialu = 0;  6'd12: ialu = 4; 6'd13: ialu = 5;
            6'd14: ialu = 6; 6'd11: ialu = 7;
            default: is_imm = 1'b0;
        endcase
        is_br = 1'b1; balu = 0;
        case (op)
            6'd4: balu = 1;  6'd5: balu = 8; 6'd7: balu = 9;
            6'd6: balu = 10; 6'd1: balu = 11;
            default: is_br = 1'b0;
        endcase
        for (int i = 0; i < fs; i++) push(ev(3,0,1,0,1,0,0,0,0,0,0,0,0,1), 1'b1, op, fn, jrz);
        push(ev(3,0,1,0,1,0,1,1,0,0,0,0,0,1), 1'b0, op, fn, jrz);
        push(ev(3,0,3,0,0,0,0,0,0,0,0,0,0,1), rbit(), op, fn, jrz);
        if (op == 6'd0 && fn == 6'd8)      ex = ev(2,1,0,0,0,0,0,1,0,0,3,0,0,1);
        else if (op == 6'd0)               ex = ev(2,1,0,0,0,0,0,0,0,0,0,0,0,1);
        else if (is_imm)                   ex = ev(ialu,1,2,0,0,0,0,0,0,0,0,0,0,1);
        else if (op == 6'd35 || op == 6'd43) ex = ev(0,1,2,0,0,0,0,0,0,0,0,0,0,1);
        else if (is_br)                    ex = ev(balu,1,0,0,0,0,0,0,1,0,1,0,0,1);
        else if (op == 6'd2)               ex = ev(0,0,0,0,0,0,0,1,0,0,2,0,0,1);
        else if (op == 6'd3)               ex = ev(0,0,0,0,0,0,0,1,0,1,2,2,0,1);
        else                               ex = ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        push(ex, rbit(), op, fn, jrz);
        if (op == 6'd35 || op == 6'd43) begin
            for (int i = 0; i <= ms; i++)
                push(ev(0,0,0,1,(op == 6'd35),(op == 6'd43),0,0,0,0,0,0,0,1),
                     (i < ms), op, fn, jrz);
        end
        if (op == 6'd35)
            push(ev(0,0,0,0,0,0,0,0,0,1,0,0,1,1), rbit(), op, fn, jrz);
        else if ((op == 6'd0 && fn != 6'd8) || is_imm)
            push(ev(0,0,0,0,0,0,0,0,0,1,0,(op == 6'd0) ? 1 : 0,0,1), rbit(), op, fn, jrz);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cyc_t c;
        int   n;
        opcode = 6'd43; waitrequest = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (act_vec !== 20'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", act_vec, 20'h0);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout: got %b want 0", mem_timeout);
        end
        @(posedge clk); #1;
        reset_n = 1'b1; waitrequest = 1'b0;
        @(negedge clk);
        checks++;
        if (act_vec !== 20'h0) begin
            errors++; $display("FAIL reset_prestart: got %h want %h", act_vec, 20'h0);
        end
        @(posedge clk); #1;
        model_instr(6'd9, 6'd0, 1'b0, 0, 0);
        model_instr(6'd9, 6'd0, 1'b0, 0, 0);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL addiu_seq cyc %0d: got %h want %h", n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_lw_stall();
        cyc_t c;
        int   n;
        model_instr(6'd35, 6'd0, 1'b0, 0, 3);
        model_instr(6'd43, 6'd0, 1'b0, 2, 1);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL lw_sw_stall cyc %0d: got %h want %h", n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL lw_no_timeout: got %b want 0", mem_timeout);
        end
    endtask

    task automatic test_branches_jumps();
        cyc_t       c;
        int         n;
        logic [5:0] ops [7];
        ops = '{6'd5, 6'd7, 6'd6, 6'd1, 6'd4, 6'd2, 6'd3};
        foreach (ops[i]) model_instr(ops[i], 6'($urandom), 1'b0, 0, 0);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL branch_jump op %0d cyc %0d: got %h want %h",
                                   c.op, n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_random();
        cyc_t       c;
        int         n;
        logic [5:0] known [16];
        logic [5:0] op, fn;
        known = '{6'd0, 6'd0, 6'd9, 6'd12, 6'd13, 6'd14, 6'd11, 6'd35,
                  6'd43, 6'd4, 6'd5, 6'd7, 6'd6, 6'd1, 6'd2, 6'd3};
        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known[$urandom_range(0, 15)];
            fn = ($urandom_range(0, 4) == 0) ? 6'd8 : 6'($urandom);
            model_instr(op, fn, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL random op %0d fn %0d cyc %0d: got %h want %h",
                                   c.op, c.fn, n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL random_no_timeout: got %b want 0", mem_timeout);
        end
    endtask

    task automatic test_halt();
        cyc_t c;
        int   n;
        model_instr(6'd0, 6'd8, 1'b1, 1, 0);
        for (int i = 0; i < 20; i++) push(20'h0, rbit(), 6'($urandom), 6'($urandom), rbit());
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL jr_halt cyc %0d: got %h want %h", n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset_mid_sw_and_timeout();
        cyc_t c;
        int   n;
        do_reset();
        model_instr(6'd43, 6'd0, 1'b0, 0, 10);
        n = 0;
        while (n < 5) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL sw_pre_reset cyc %0d: got %h want %h", n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
        q.delete();
        waitrequest = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++; $display("FAIL sw_mem_write_held: got %b want 1", mem_write);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            errors++; $display("FAIL reset_drops_mem: got %b want 00", {mem_read, mem_write});
        end
        @(posedge clk); #1;
        reset_n = 1'b1; waitrequest = 1'b0;
        @(posedge clk); #1;
        // two 4-cycle stalls must not accumulate; a 6-cycle stall must trip the flag
        model_instr(6'd9, 6'd0, 1'b0, 4, 0);
        model_instr(6'd43, 6'd0, 1'b0, 0, 4);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL short_stalls cyc %0d: got %h want %h", n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_below_limit: got %b want 0", mem_timeout);
        end
        model_instr(6'd13, 6'd0, 1'b0, 6, 0);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL long_stall cyc %0d: got %h want %h", n, act_vec, c.e);
            end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_set: got %b want 1", mem_timeout);
        end
        model_instr(6'd35, 6'd0, 1'b0, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; funct = c.fn; jr_target_zero = c.jrz; waitrequest = c.wr;
            @(negedge clk);
            checks++;
            if (act_vec !== c.e) begin
                errors++; $display("FAIL post_timeout_lw: got %h want %h", act_vec, c.e);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_branches_jumps();
        test_random();
        test_halt();
        test_reset_mid_sw_and_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
